// File: rtl/fifo_burst_reader.sv
// Pops a requested number of words from a synchronous FIFO and replays them on a
// valid/ready stream through a 2-entry skid buffer, with abort and completion status.
module fifo_burst_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  len,
    input  logic                  abort,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_rd,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    output logic                  m_last,
    input  logic                  m_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  aborted,
    output logic [LEN_WIDTH-1:0]  sent,
    output logic [1:0]            dbg_state
);

    // Stream: a word transfers on a rising edge where m_valid & m_ready; once m_valid
    // is high, m_data/m_last hold until that transfer, and m_valid never depends on m_ready.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BURST = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                           state_q, state_d;
    logic [LEN_WIDTH-1:0]             remaining_q, remaining_d;
    logic [LEN_WIDTH-1:0]             sent_q, sent_d;
    logic [1:0]                       occ_q, occ_d;
    logic [1:0][DATA_WIDTH-1:0]       buf_data_q, buf_data_d;
    logic [1:0]                       buf_last_q, buf_last_d;
    logic                             aborted_q, aborted_d;
    logic                             push, pop, abort_act;
    logic [1:0]                       occ_after_pop;

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        sent_d      = sent_q;
        buf_data_d  = buf_data_q;
        buf_last_d  = buf_last_q;
        aborted_d   = aborted_q;

        m_valid   = (occ_q != 2'd0);
        pop       = m_valid && m_ready;
        abort_act = abort && ((state_q == S_BURST) || (state_q == S_DRAIN));
        push      = (state_q == S_BURST) && (remaining_q != '0) && !fifo_empty
                    && (occ_q < 2'd2) && !abort;
        fifo_rd   = push;

        // Head is always entry 0; a pop shifts entry 1 forward before any push lands.
        occ_after_pop = occ_q - {1'b0, pop};
        if (pop) begin
            buf_data_d[0] = buf_data_q[1];
            buf_last_d[0] = buf_last_q[1];
            sent_d        = sent_q + LEN_WIDTH'(1);
        end
        if (push) begin
            remaining_d = remaining_q - LEN_WIDTH'(1);
            if (occ_after_pop == 2'd0) begin
                buf_data_d[0] = fifo_data;
                buf_last_d[0] = (remaining_q == LEN_WIDTH'(1));
            end else begin
                buf_data_d[1] = fifo_data;
                buf_last_d[1] = (remaining_q == LEN_WIDTH'(1));
            end
        end
        occ_d = occ_after_pop + {1'b0, push};

        unique case (state_q)
            S_IDLE: begin
                if (start && (len != '0)) begin
                    state_d     = S_BURST;
                    remaining_d = len;
                    sent_d      = '0;
                    aborted_d   = 1'b0;
                end
            end
            S_BURST: begin
                if (abort_act) begin
                    state_d   = S_DONE;
                    occ_d     = 2'd0;
                    aborted_d = 1'b1;
                end else if (push && (remaining_q == LEN_WIDTH'(1))) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (abort_act) begin
                    state_d   = S_DONE;
                    occ_d     = 2'd0;
                    aborted_d = 1'b1;
                end else if (pop && buf_last_q[0]) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            remaining_q <= '0;
            sent_q      <= '0;
            occ_q       <= 2'd0;
            buf_data_q  <= '0;
            buf_last_q  <= '0;
            aborted_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            sent_q      <= sent_d;
            occ_q       <= occ_d;
            buf_data_q  <= buf_data_d;
            buf_last_q  <= buf_last_d;
            aborted_q   <= aborted_d;
        end
    end

    // m_last is qualified so a stale tag left behind by a flush never shows.
    assign m_data    = buf_data_q[0];
    assign m_last    = m_valid && buf_last_q[0];
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign aborted   = aborted_q;
    assign sent      = sent_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader: behavioural sync FIFO, stream scoreboard,
// and per-cycle checks against hand-computed values.
module tb_fifo_burst_reader;

    localparam int DW = 8;
    localparam int LW = 8;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BURST = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic          clk;
    logic          rst;
    logic          start;
    logic [LW-1:0] len;
    logic          abort;
    logic          fifo_empty;
    logic [DW-1:0] fifo_data;
    logic          fifo_rd;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_last;
    logic          m_ready;
    logic          busy;
    logic          done;
    logic          aborted;
    logic [LW-1:0] sent;
    logic [1:0]    dbg_state;

    fifo_burst_reader #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .len        (len),
        .abort      (abort),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd    (fifo_rd),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_last     (m_last),
        .m_ready    (m_ready),
        .busy       (busy),
        .done       (done),
        .aborted    (aborted),
        .sent       (sent),
        .dbg_state  (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // behavioural FIFO: combinational head, popped on the edge where fifo_rd is high
    logic [DW-1:0] mem [0:15];
    int            wr_ptr = 0;
    int            rd_ptr = 0;
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_data  = mem[rd_ptr[3:0]];
    always @(posedge clk) if (fifo_rd) rd_ptr <= rd_ptr + 1;

    // scoreboard: {last, data}
    logic [DW:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;
    int n_pops   = 0;
    int n_done   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic fifo_write(input logic [DW-1:0] d);
        mem[wr_ptr[3:0]] = d;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic expect_word(input logic [DW-1:0] d, input logic last);
        exp_q.push_back({last, d});
    endtask

    // Samples the settled cycle (handshake, pop, done), then advances to 1ns past the next edge.
    task automatic tick();
        logic [DW:0] e;
        #1;
        if (!rst && m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                check_eq("sb_unexpected_word", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                check_eq("sb_data", 32'(m_data), 32'(e[DW-1:0]));
                check_eq("sb_last", 32'(m_last), 32'(e[DW]));
            end
        end
        if (fifo_rd) n_pops++;
        if (done) n_done++;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int max_cycles);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < max_cycles && !seen; i++) begin
            tick();
            if (done) seen = 1'b1;
        end
        check_eq("wait_done", 32'(done), 32'd1);
    endtask

    int pops0;

    initial begin
        rst = 1'b1; start = 1'b0; len = '0; abort = 1'b0; m_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        // reset state
        check_eq("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_aborted", 32'(aborted), 32'd0);
        check_eq("rst_m_valid", 32'(m_valid), 32'd0);
        check_eq("rst_m_last", 32'(m_last), 32'd0);
        check_eq("rst_m_data", 32'(m_data), 32'd0);
        check_eq("rst_sent", 32'(sent), 32'd0);
        check_eq("rst_fifo_rd", 32'(fifo_rd), 32'd0);
        // rst wins over start
        start = 1'b1; len = 8'd3;
        tick();
        check_eq("rst_over_start", 32'(busy), 32'd0);
        rst = 1'b0; start = 1'b0;
        tick();

        // basic burst: A0..A3 in FIFO, len=3
        fifo_write(8'hA0); fifo_write(8'hA1); fifo_write(8'hA2); fifo_write(8'hA3);
        expect_word(8'hA0, 1'b0); expect_word(8'hA1, 1'b0); expect_word(8'hA2, 1'b1);
        m_ready = 1'b1; start = 1'b1; len = 8'd3;
        tick();
        start = 1'b0; #1;
        check_eq("b_state_burst", 32'(dbg_state), 32'(ST_BURST));
        check_eq("b_rd0", 32'(fifo_rd), 32'd1);
        check_eq("b_valid0", 32'(m_valid), 32'd0);
        tick();
        check_eq("b_rd1", 32'(fifo_rd), 32'd1);
        check_eq("b_data_a0", 32'(m_data), 32'hA0);
        check_eq("b_last_a0", 32'(m_last), 32'd0);
        tick();
        check_eq("b_rd2", 32'(fifo_rd), 32'd1);
        check_eq("b_data_a1", 32'(m_data), 32'hA1);
        tick();
        check_eq("b_rd3", 32'(fifo_rd), 32'd0);
        check_eq("b_data_a2", 32'(m_data), 32'hA2);
        check_eq("b_last_a2", 32'(m_last), 32'd1);
        check_eq("b_state_drain", 32'(dbg_state), 32'(ST_DRAIN));
        tick();
        check_eq("b_done", 32'(done), 32'd1);
        check_eq("b_sent", 32'(sent), 32'd3);
        check_eq("b_aborted", 32'(aborted), 32'd0);
        check_eq("b_valid_end", 32'(m_valid), 32'd0);
        tick();
        check_eq("b_done_pulse", 32'(done), 32'd0);
        check_eq("b_idle", 32'(busy), 32'd0);
        check_eq("b_fifo_left", 32'(wr_ptr - rd_ptr), 32'd1);
        check_eq("b_fifo_head", 32'(fifo_data), 32'hA3);
        check_eq("b_sb_empty", 32'(exp_q.size()), 32'd0);

        // backpressure: FIFO holds A3,B0,B1,B2; len=4 with m_ready low
        fifo_write(8'hB0); fifo_write(8'hB1); fifo_write(8'hB2);
        expect_word(8'hA3, 1'b0); expect_word(8'hB0, 1'b0);
        expect_word(8'hB1, 1'b0); expect_word(8'hB2, 1'b1);
        m_ready = 1'b0; pops0 = n_pops;
        start = 1'b1; len = 8'd4;
        tick();
        start = 1'b0; #1;
        check_eq("bp_rd0", 32'(fifo_rd), 32'd1);
        tick();
        check_eq("bp_rd1", 32'(fifo_rd), 32'd1);
        check_eq("bp_data0", 32'(m_data), 32'hA3);
        tick();
        check_eq("bp_rd_full", 32'(fifo_rd), 32'd0);
        repeat (4) tick();
        check_eq("bp_rd_hold", 32'(fifo_rd), 32'd0);
        check_eq("bp_data_hold", 32'(m_data), 32'hA3);
        check_eq("bp_valid_hold", 32'(m_valid), 32'd1);
        check_eq("bp_pops", 32'(n_pops - pops0), 32'd2);
        check_eq("bp_state", 32'(dbg_state), 32'(ST_BURST));
        m_ready = 1'b1;
        wait_done(50);
        check_eq("bp_sent", 32'(sent), 32'd4);
        check_eq("bp_sb_empty", 32'(exp_q.size()), 32'd0);
        tick();

        // underflow: one word present, len=2
        fifo_write(8'hC0);
        expect_word(8'hC0, 1'b0); expect_word(8'hC1, 1'b1);
        start = 1'b1; len = 8'd2;
        tick();
        start = 1'b0; #1;
        check_eq("uf_rd0", 32'(fifo_rd), 32'd1);
        tick();
        check_eq("uf_rd_empty", 32'(fifo_rd), 32'd0);
        check_eq("uf_data0", 32'(m_data), 32'hC0);
        repeat (5) tick();
        check_eq("uf_state", 32'(dbg_state), 32'(ST_BURST));
        check_eq("uf_rd_wait", 32'(fifo_rd), 32'd0);
        check_eq("uf_busy", 32'(busy), 32'd1);
        fifo_write(8'hC1); #1;
        check_eq("uf_rd_resume", 32'(fifo_rd), 32'd1);
        wait_done(20);
        check_eq("uf_sent", 32'(sent), 32'd2);
        check_eq("uf_aborted", 32'(aborted), 32'd0);
        tick();

        // abort after two handshakes, len=5
        fifo_write(8'hD0); fifo_write(8'hD1); fifo_write(8'hD2);
        fifo_write(8'hD3); fifo_write(8'hD4);
        expect_word(8'hD0, 1'b0); expect_word(8'hD1, 1'b0);
        m_ready = 1'b1; start = 1'b1; len = 8'd5;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        check_eq("ab_sent_pre", 32'(sent), 32'd2);
        check_eq("ab_head", 32'(m_data), 32'hD2);
        abort = 1'b1; m_ready = 1'b0; #1;
        check_eq("ab_rd_gated", 32'(fifo_rd), 32'd0);
        tick();
        abort = 1'b0; #1;
        check_eq("ab_flush", 32'(m_valid), 32'd0);
        check_eq("ab_done", 32'(done), 32'd1);
        check_eq("ab_aborted", 32'(aborted), 32'd1);
        check_eq("ab_sent", 32'(sent), 32'd2);
        check_eq("ab_state", 32'(dbg_state), 32'(ST_DONE));
        tick();
        check_eq("ab_done_pulse", 32'(done), 32'd0);
        check_eq("ab_aborted_hold", 32'(aborted), 32'd1);
        check_eq("ab_fifo_left", 32'(wr_ptr - rd_ptr), 32'd2);
        check_eq("ab_sb_empty", 32'(exp_q.size()), 32'd0);

        // start filtering, then reset during DRAIN (FIFO holds D3,D4)
        start = 1'b1; len = 8'd0;
        tick();
        start = 1'b0; #1;
        check_eq("len0_busy", 32'(busy), 32'd0);
        check_eq("len0_aborted_hold", 32'(aborted), 32'd1);
        m_ready = 1'b0; start = 1'b1; len = 8'd2;
        tick();
        len = 8'd7; #1;
        check_eq("sf_busy", 32'(busy), 32'd1);
        check_eq("sf_aborted_clr", 32'(aborted), 32'd0);
        tick(); tick();
        start = 1'b0; #1;
        check_eq("sf_state_drain", 32'(dbg_state), 32'(ST_DRAIN));
        check_eq("sf_head", 32'(m_data), 32'hD3);
        rst = 1'b1;
        tick();
        check_eq("rd_state", 32'(dbg_state), 32'(ST_IDLE));
        check_eq("rd_busy", 32'(busy), 32'd0);
        check_eq("rd_done", 32'(done), 32'd0);
        check_eq("rd_valid", 32'(m_valid), 32'd0);
        check_eq("rd_last", 32'(m_last), 32'd0);
        check_eq("rd_data", 32'(m_data), 32'd0);
        check_eq("rd_sent", 32'(sent), 32'd0);
        check_eq("rd_fifo_rd", 32'(fifo_rd), 32'd0);
        rst = 1'b0;
        tick();
        check_eq("rd_no_done", 32'(done), 32'd0);
        check_eq("done_pulses", 32'(n_done), 32'd4);
        check_eq("rd_fifo_empty", 32'(wr_ptr - rd_ptr), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
